// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmit arbiter: FSM encoding, timeout counter width
// and the baud divisor loaded at reset.
package usart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int TO_W  = 16;
  localparam int CPB_W = 12;
  localparam logic [CPB_W-1:0] CPB_RESET = 12'd0;

endpackage

// File: rtl/usart_rr_picker.sv
// Round-robin winner select: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
// Purely combinational, no state and no backpressure.
module usart_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       any,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic [$clog2(NUM_REQ)-1:0] win_idx
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] first;

  always_comb begin
    // Rotate so rr_ptr lands on bit 0, isolate the lowest set bit, rotate back.
    rot     = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    first   = rot & ~(rot - 1'b1);
    win_oh  = NUM_REQ'(({first, first} << rr_ptr) >> NUM_REQ);
    any     = |req_valid;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[PW'(i)]) win_idx = PW'(i);
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Round-robin sharing of one usart_tx among NUM_REQ byte requesters, with locked bursts and the baud register.
// Accept 1 cycle after req_valid; requesters stall while another holds the grant; tx_latch holds until tx_ready.
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int                 NUM_REQ     = 4,
  parameter int                 MAX_BURST   = 16,
  parameter int                 TIMEOUT     = 1024,
  parameter logic [CPB_W-1:0]   DEFAULT_CPB = CPB_RESET
) (
  input  logic                       serial_clock,
  input  logic                       reset_n,
  input  logic                       cfg_write,
  input  logic [CPB_W-1:0]           cfg_clocks_per_bit,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_accept,
  output logic [NUM_REQ-1:0]         req_sent,
  output logic [7:0]                 tx_data,
  output logic                       tx_latch,
  input  logic                       tx_ready,
  input  logic                       tx_done,
  output logic [CPB_W-1:0]           tx_clocks_per_bit,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int              GW        = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [7:0]      BURST_MAX = 8'(MAX_BURST);

  state_t             state, state_n;
  logic [GW-1:0]      rr_ptr, rr_n, grant_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic [7:0]         burst_cnt, burst_n, data_n;
  logic               last_q, last_n, latch_n, terr_n, release_grant;
  logic [NUM_REQ-1:0] acc_n, sent_n;
  logic [CPB_W-1:0]   cpb_n;
  logic [7:0]         data_arr [NUM_REQ];

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_oh;
  logic [GW-1:0]      pick_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[8*i +: 8];
  end

  usart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .win_oh    (pick_oh),
    .win_idx   (pick_idx)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_n       = state;
    rr_n          = rr_ptr;
    grant_n       = grant_id;
    data_n        = tx_data;
    last_n        = last_q;
    burst_n       = burst_cnt;
    to_n          = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
    latch_n       = 1'b0;
    acc_n         = '0;
    sent_n        = '0;
    terr_n        = 1'b0;
    cpb_n         = tx_clocks_per_bit;
    release_grant = 1'b0;

    case (state)
      ST_IDLE: begin
        to_n = '0;
        if (cfg_write) cpb_n = cfg_clocks_per_bit;
        if (pick_any) begin
          state_n = ST_LATCH;
          grant_n = pick_idx;
          data_n  = data_arr[pick_idx];
          last_n  = req_last[pick_idx];
          acc_n   = pick_oh;
          latch_n = 1'b1;
        end
      end
      ST_LATCH: begin
        if (tx_ready) begin
          state_n = ST_SEND;
          to_n    = '0;
        end else if (to_cnt >= TO_LAST) begin
          terr_n        = 1'b1;
          release_grant = 1'b1;
        end else begin
          latch_n = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          sent_n[grant_id] = 1'b1;
          burst_n          = burst_cnt + 8'd1;
          if (last_q || burst_n >= BURST_MAX) begin
            release_grant = 1'b1;
          end else begin
            state_n = ST_HOLD;
            to_n    = '0;
          end
        end
      end
      ST_HOLD: begin
        // Only the burst owner may continue; everyone else waits for the release.
        if (req_valid[grant_id]) begin
          state_n          = ST_LATCH;
          to_n             = '0;
          data_n           = data_arr[grant_id];
          last_n           = req_last[grant_id];
          acc_n[grant_id]  = 1'b1;
          latch_n          = 1'b1;
        end else if (to_cnt >= TO_LAST) begin
          terr_n        = 1'b1;
          release_grant = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (release_grant) begin
      state_n = ST_IDLE;
      rr_n    = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      burst_n = '0;
      to_n    = '0;
    end
  end

  always_ff @(posedge serial_clock) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      rr_ptr            <= '0;
      grant_id          <= '0;
      tx_data           <= '0;
      last_q            <= 1'b0;
      burst_cnt         <= '0;
      to_cnt            <= '0;
      tx_latch          <= 1'b0;
      req_accept        <= '0;
      req_sent          <= '0;
      timeout_err       <= 1'b0;
      tx_clocks_per_bit <= DEFAULT_CPB;
    end else begin
      state             <= state_n;
      rr_ptr            <= rr_n;
      grant_id          <= grant_n;
      tx_data           <= data_n;
      last_q            <= last_n;
      burst_cnt         <= burst_n;
      to_cnt            <= to_n;
      tx_latch          <= latch_n;
      req_accept        <= acc_n;
      req_sent          <= sent_n;
      timeout_err       <= terr_n;
      tx_clocks_per_bit <= cpb_n;
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Bench for usart_tx_arbiter: requester queues, a behavioural usart_tx stub and a scoreboard monitor.
module tb_usart_tx_arbiter;

  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int TO    = 64;
  localparam int FRAME = 10;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cfg_write;
  logic [11:0]     cfg_clocks_per_bit;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_accept;
  logic [NR-1:0]   req_sent;
  logic [7:0]      tx_data;
  logic            tx_latch;
  logic            tx_ready;
  logic            tx_done;
  logic [11:0]     tx_clocks_per_bit;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  always #5 clk = ~clk;

  usart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TO), .DEFAULT_CPB(12'd0)) dut (
    .serial_clock       (clk),
    .reset_n            (reset_n),
    .cfg_write          (cfg_write),
    .cfg_clocks_per_bit (cfg_clocks_per_bit),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_last           (req_last),
    .req_accept         (req_accept),
    .req_sent           (req_sent),
    .tx_data            (tx_data),
    .tx_latch           (tx_latch),
    .tx_ready           (tx_ready),
    .tx_done            (tx_done),
    .tx_clocks_per_bit  (tx_clocks_per_bit),
    .busy               (busy),
    .grant_id           (grant_id),
    .timeout_err        (timeout_err)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [8:0]  rq [NR][$];
  int          exp_acc_id[$];
  logic [7:0]  exp_acc_dat[$];
  int          exp_sent[$];
  int          exp_to[$];
  logic [7:0]  exp_tx[$];
  bit          stub_en   = 1'b1;
  bit          stub_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d, input bit sent);
    exp_acc_id.push_back(id);
    exp_acc_dat.push_back(d);
    exp_tx.push_back(d);
    if (sent) exp_sent.push_back(id);
  endtask

  function automatic bit idle_all();
    bit q_empty = 1'b1;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) q_empty = 1'b0;
    return q_empty && !busy && !stub_busy && exp_acc_id.size() == 0 &&
           exp_sent.size() == 0 && exp_tx.size() == 0 && exp_to.size() == 0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !idle_all()) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!idle_all()) begin
      failures++;
      $display("FAIL %s_drain act=busy%0b/acc%0d/sent%0d/tx%0d exp=all_idle", name, busy,
               exp_acc_id.size(), exp_sent.size(), exp_tx.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Requesters: present the queue head, pop it once the DUT pulses req_accept.
  initial begin
    logic [NR-1:0]   vld, lst;
    logic [NR*8-1:0] dat;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(posedge clk); #2;
      vld = '0; lst = '0; dat = '0;
      for (int i = 0; i < NR; i++) begin
        if (req_accept[2'(i)] && rq[i].size() > 0) rq[i].delete(0);
        if (rq[i].size() > 0) begin
          vld |= NR'(1) << i;
          lst |= NR'(rq[i][0][8]) << i;
          dat |= (NR*8)'(rq[i][0][7:0]) << (8 * i);
        end
      end
      req_valid = vld; req_last = lst; req_data = dat;
    end
  end

  // usart_tx stand-in: one-cycle ready ack, then a done pulse FRAME cycles later.
  initial begin
    int cnt;
    cnt = 0; tx_ready = 1'b0; tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (stub_busy) begin
        tx_ready = 1'b0;
        if (cnt == 0) begin
          tx_done   = 1'b1;
          stub_busy = 1'b0;
        end else begin
          tx_done = 1'b0;
          cnt--;
        end
      end else begin
        tx_done = 1'b0;
        if (tx_latch && stub_en && !tx_ready) begin
          tx_ready  = 1'b1;
          stub_busy = 1'b1;
          cnt       = FRAME;
          if (exp_tx.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_byte act=%0h exp=none", tx_data);
          end else begin
            chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
          end
        end else begin
          tx_ready = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    int id;
    forever begin
      @(negedge clk);
      if (req_accept != '0) begin
        if (exp_acc_id.size() == 0) begin
          checks++; failures++;
          $display("FAIL accept act=%b exp=none", req_accept);
        end else begin
          id = exp_acc_id.pop_front();
          chk("accept_onehot", 32'(req_accept), 32'(NR'(1) << id));
          chk("accept_grant", 32'(grant_id), id);
          chk("accept_data", 32'(tx_data), 32'(exp_acc_dat.pop_front()));
        end
      end
      if (req_sent != '0) begin
        if (exp_sent.size() == 0) begin
          checks++; failures++;
          $display("FAIL sent act=%b exp=none", req_sent);
        end else begin
          id = exp_sent.pop_front();
          chk("sent_onehot", 32'(req_sent), 32'(NR'(1) << id));
        end
      end
      if (timeout_err) begin
        if (exp_to.size() == 0) begin
          checks++; failures++;
          $display("FAIL timeout act=1 exp=none");
        end else begin
          chk("timeout_grant", 32'(grant_id), exp_to.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, lat;
    cfg_write = 1'b0;
    cfg_clocks_per_bit = '0;
    do_reset();
    chk("rst_accept", 32'(req_accept), 0);
    chk("rst_sent", 32'(req_sent), 0);
    chk("rst_latch", 32'(tx_latch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_cpb", 32'(tx_clocks_per_bit), 0);

    // 1: single requester, one-cycle accept latency
    expect_byte(2, 8'hAA, 1'b1);
    rq[2].push_back({1'b1, 8'hAA});
    @(posedge clk); #1;
    chk("t1_accept_latency", 32'(req_accept), 32'b0100);
    chk("t1_latch", 32'(tx_latch), 1);
    chk("t1_busy", 32'(busy), 1);
    drain("t1", 300);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_grant_kept", 32'(grant_id), 2);

    // 2: all four requesting, two rounds
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) expect_byte(i, 8'(8'h10 + 4 * r + i), 1'b1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) rq[i].push_back({1'b1, 8'(8'h10 + 4 * r + i)});
    drain("t2", 800);

    // 3: locked burst forced out after MAX_BURST bytes
    do_reset();
    for (int b = 0; b < 4; b++) expect_byte(1, 8'(8'h20 + b), 1'b1);
    expect_byte(3, 8'h30, 1'b1);
    expect_byte(1, 8'h24, 1'b1);
    expect_byte(1, 8'h25, 1'b1);
    for (int b = 0; b < 6; b++) rq[1].push_back({(b == 5), 8'(8'h20 + b)});
    rq[3].push_back({1'b1, 8'h30});
    drain("t3", 800);

    // 4: no ack from the transmitter
    do_reset();
    stub_en = 1'b0;
    exp_acc_id.push_back(0); exp_acc_dat.push_back(8'h40);
    exp_to.push_back(0);
    expect_byte(1, 8'h41, 1'b1);
    expect_byte(0, 8'h42, 1'b1);
    rq[0].push_back({1'b1, 8'h40});
    rq[0].push_back({1'b1, 8'h42});
    rq[1].push_back({1'b1, 8'h41});
    n = 0;
    while (!tx_latch && n < 20) begin @(posedge clk); #1; n++; end
    lat = 0;
    while (tx_latch && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("t4_latch_cycles", lat, TO);
    chk("t4_timeout_pulse", 32'(timeout_err), 1);
    chk("t4_released", 32'(busy), 0);
    stub_en = 1'b1;
    drain("t4", 400);

    // 5: baud register only writable in IDLE
    expect_byte(0, 8'h50, 1'b1);
    rq[0].push_back({1'b1, 8'h50});
    n = 0;
    while (!busy && n < 20) begin @(posedge clk); #1; n++; end
    cfg_clocks_per_bit = 12'd5; cfg_write = 1'b1;
    @(posedge clk); #1;
    cfg_write = 1'b0;
    chk("t5_busy", 32'(busy), 1);
    chk("t5_cpb_busy", 32'(tx_clocks_per_bit), 0);
    drain("t5a", 300);
    cfg_clocks_per_bit = 12'd5; cfg_write = 1'b1;
    @(posedge clk); #1;
    cfg_write = 1'b0;
    chk("t5_cpb_idle", 32'(tx_clocks_per_bit), 5);
    expect_byte(0, 8'h51, 1'b1);
    rq[0].push_back({1'b1, 8'h51});
    cfg_clocks_per_bit = 12'd7; cfg_write = 1'b1;
    @(posedge clk); #1;
    cfg_write = 1'b0;
    chk("t5_cpb_with_win", 32'(tx_clocks_per_bit), 7);
    chk("t5_accept_with_cfg", 32'(req_accept), 32'b0001);
    drain("t5b", 300);

    // 6: reset during SEND
    do_reset();
    chk("t6_cpb_reset", 32'(tx_clocks_per_bit), 0);
    exp_acc_id.push_back(2); exp_acc_dat.push_back(8'h60); exp_tx.push_back(8'h60);
    rq[2].push_back({1'b1, 8'h60});
    n = 0;
    while (!tx_latch && n < 20) begin @(posedge clk); #1; n++; end
    while (tx_latch && n < 100) begin @(posedge clk); #1; n++; end
    chk("t6_in_send", 32'(busy), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_latch", 32'(tx_latch), 0);
    chk("t6_busy", 32'(busy), 0);
    reset_n = 1'b1;
    expect_byte(0, 8'h70, 1'b1);
    expect_byte(3, 8'h63, 1'b1);
    rq[3].push_back({1'b1, 8'h63});
    rq[0].push_back({1'b1, 8'h70});
    drain("t6", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
